dec2onehot_led: RTL and testbench

//  Reverse path of the doorlock keypad decode: takes 4-bit digit codes (0-9) and replays them on the 10 board LEDs.

---
 rtl/dec2onehot_led_pkg.sv | 39 +++
 rtl/dec2onehot_led_if.sv | 29 ++
 rtl/dec2onehot_led_fifo.sv | 84 ++++++++
 rtl/dec2onehot_led.sv | 164 ++++++++++++++++
 tb/tb_dec2onehot_led.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/dec2onehot_led_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dec2onehot_led_pkg
// Description : Shared types and helpers for the digit-to-LED echo block.
//               Holds the display FSM state encoding, the LED pattern used
//               for out-of-range codes and the digit-to-one-hot mapping.
// Revision    : 1.0 - initial release
// ============================================================================
package dec2onehot_led_pkg;

  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned LED_W   = 10;

  localparam logic [LED_W-1:0]   LED_INVALID = 10'h3FF;
  localparam logic [DIGIT_W-1:0] DIGIT_MAX   = 4'h9;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SHOW = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  function automatic logic is_valid_digit(input logic [DIGIT_W-1:0] d);
    return (d <= DIGIT_MAX);
  endfunction

  // Codes 0-9 light the LED at the same index; anything else lights all LEDs
  // so a bad code is impossible to mistake for a real digit.
  function automatic logic [LED_W-1:0] digit_to_onehot(input logic [DIGIT_W-1:0] d);
    logic [LED_W-1:0] pat;
    pat = LED_INVALID;
    if (is_valid_digit(d)) begin
      pat = 10'b00_0000_0001 << d;
    end
    return pat;
  endfunction

endpackage : dec2onehot_led_pkg
`default_nettype wire

// File: rtl/dec2onehot_led_if.sv
`default_nettype none
// ============================================================================
// Module      : dec2onehot_led_if
// Description : Valid/ready digit stream feeding the LED echo block.
//               digit_in    - 4-bit digit code (0-9 valid, A-F invalid)
//               digit_valid - producer offers digit_in this cycle
//               digit_ready - consumer can accept; transfer on valid & ready
// Revision    : 1.0 - initial release
// ============================================================================
interface dec2onehot_led_if;

  logic [3:0] digit_in;
  logic       digit_valid;
  logic       digit_ready;

  modport master (
    output digit_in,
    output digit_valid,
    input  digit_ready
  );

  modport slave (
    input  digit_in,
    input  digit_valid,
    output digit_ready
  );

endinterface : dec2onehot_led_if
`default_nettype wire

// File: rtl/dec2onehot_led_fifo.sv
`default_nettype none
// ============================================================================
// Module      : dec2onehot_led_fifo
// Description : DEPTH x DATA_W synchronous first-word-fall-through FIFO with
//               flush. o_dout always shows the oldest entry while non-empty.
// Ports       : clk, rst_n       - clock, async active-low reset
//               i_push / i_din   - write strobe and data (ignored when full)
//               i_pop            - consume oldest entry (ignored when empty)
//               i_flush          - empty the FIFO; overrides push and pop
//               o_dout           - oldest entry
//               o_full / o_empty - occupancy flags
//               o_count          - number of stored entries
// Revision    : 1.0 - initial release
// ============================================================================
module dec2onehot_led_fifo #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 4
) (
  input  wire logic                     clk,
  input  wire logic                     rst_n,
  input  wire logic                     i_push,
  input  wire logic [DATA_W-1:0]        i_din,
  input  wire logic                     i_pop,
  input  wire logic                     i_flush,
  output logic      [DATA_W-1:0]        o_dout,
  output logic                          o_full,
  output logic                          o_empty,
  output logic      [$clog2(DEPTH):0]   o_count
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] c_depth = (AW+1)'(DEPTH);

  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [AW-1:0]     r_wr_ptr;
  logic [AW-1:0]     r_rd_ptr;
  logic [AW:0]       r_count;

  logic w_do_push;
  logic w_do_pop;

  assign w_do_push = i_push & ~o_full  & ~i_flush;
  assign w_do_pop  = i_pop  & ~o_empty & ~i_flush;

  // Pointers are exactly log2(DEPTH) bits, so they wrap modulo DEPTH for free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      unique case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Storage carries no reset; stale words are unreachable once the
  // pointers are cleared.
  always_ff @(posedge clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_din;
    end
  end

  assign o_dout  = r_mem[r_rd_ptr];
  assign o_full  = (r_count == c_depth);
  assign o_empty = (r_count == '0);
  assign o_count = r_count;

endmodule : dec2onehot_led_fifo
`default_nettype wire

// File: rtl/dec2onehot_led.sv
`default_nettype none
// ============================================================================
// Module      : dec2onehot_led
// Description : Replays buffered 4-bit digit codes on 10 LEDs as one-hot
//               patterns. Each digit is lit for HOLD_CYC cycles followed by a
//               blank gap of GAP_CYC cycles. Invalid codes light all LEDs and
//               set a sticky flag.
// Ports       : clk            - system clock
//               rst_n          - asynchronous active-low reset
//               s_digit        - valid/ready digit stream (slave side)
//               i_clear        - synchronous flush of FIFO and display
//               o_led          - registered one-hot display pattern
//               o_busy         - FIFO non-empty or display not idle
//               o_invalid_seen - sticky: an invalid code was displayed
// Revision    : 1.0 - initial release
// ============================================================================
module dec2onehot_led
  import dec2onehot_led_pkg::*;
#(
  parameter int DEPTH    = 4,
  parameter int HOLD_CYC = 25_000_000,
  parameter int GAP_CYC  = 5_000_000,
  parameter int CNT_W    = 25
) (
  input  wire logic              clk,
  input  wire logic              rst_n,
  dec2onehot_led_if.slave        s_digit,
  input  wire logic              i_clear,
  output logic [LED_W-1:0]       o_led,
  output logic                   o_busy,
  output logic                   o_invalid_seen
);

  localparam int CW = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] c_hold_load = CNT_W'(HOLD_CYC - 1);
  localparam logic [CNT_W-1:0] c_gap_load  = (GAP_CYC > 0) ? CNT_W'(GAP_CYC - 1) : '0;

  state_t             r_state;
  logic [CNT_W-1:0]   r_timer;
  logic [LED_W-1:0]   r_led;
  logic               r_invalid_seen;

  state_t             w_state_nxt;
  logic [CNT_W-1:0]   w_timer_nxt;
  logic [LED_W-1:0]   w_led_nxt;
  logic               w_invalid_nxt;
  logic               w_load;
  logic               w_pop;
  logic               w_push;

  logic [DIGIT_W-1:0] w_fifo_dout;
  logic               w_fifo_full;
  logic               w_fifo_empty;
  logic [CW:0]        w_fifo_count;

  // ---------------------------------------------------------------------------
  // Input buffer. A digit offered in the same cycle as clear is dropped.
  // ---------------------------------------------------------------------------
  assign s_digit.digit_ready = ~w_fifo_full;
  assign w_push              = s_digit.digit_valid & ~w_fifo_full & ~i_clear;

  dec2onehot_led_fifo #(
    .DEPTH  (DEPTH),
    .DATA_W (DIGIT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_din   (s_digit.digit_in),
    .i_pop   (w_pop),
    .i_flush (i_clear),
    .o_dout  (w_fifo_dout),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty),
    .o_count (w_fifo_count)
  );

  // ---------------------------------------------------------------------------
  // Display sequencer: state, timer, LED pattern and sticky flag.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state        <= ST_IDLE;
      r_timer        <= '0;
      r_led          <= '0;
      r_invalid_seen <= 1'b0;
    end else begin
      r_state        <= w_state_nxt;
      r_timer        <= w_timer_nxt;
      r_led          <= w_led_nxt;
      r_invalid_seen <= w_invalid_nxt;
    end
  end

  always_comb begin
    w_state_nxt   = r_state;
    w_timer_nxt   = r_timer;
    w_led_nxt     = r_led;
    w_invalid_nxt = r_invalid_seen;
    w_load        = 1'b0;
    w_pop         = 1'b0;

    if (i_clear) begin
      w_state_nxt   = ST_IDLE;
      w_timer_nxt   = '0;
      w_led_nxt     = '0;
      w_invalid_nxt = 1'b0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          w_load = ~w_fifo_empty;
        end

        ST_SHOW: begin
          if (r_timer == '0) begin
            w_led_nxt = '0;
            if (GAP_CYC > 0) begin
              w_timer_nxt = c_gap_load;
              w_state_nxt = ST_GAP;
            end else begin
              // No gap configured: behave as if the gap just expired, so the
              // next queued digit follows without a blank cycle.
              w_load      = ~w_fifo_empty;
              w_state_nxt = ST_IDLE;
            end
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end

        ST_GAP: begin
          if (r_timer == '0) begin
            w_load      = ~w_fifo_empty;
            w_state_nxt = ST_IDLE;
          end else begin
            w_timer_nxt = r_timer - 1'b1;
          end
        end

        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
          w_led_nxt   = '0;
        end
      endcase

      // Common "start showing the oldest digit" action, shared by IDLE and
      // both hold/gap expiry paths; it overrides the IDLE fallback above.
      if (w_load) begin
        w_pop         = 1'b1;
        w_led_nxt     = digit_to_onehot(w_fifo_dout);
        w_invalid_nxt = r_invalid_seen | ~is_valid_digit(w_fifo_dout);
        w_timer_nxt   = c_hold_load;
        w_state_nxt   = ST_SHOW;
      end
    end
  end

  assign o_led          = r_led;
  assign o_invalid_seen = r_invalid_seen;
  assign o_busy         = (r_state != ST_IDLE) | (w_fifo_count != '0);

endmodule : dec2onehot_led
`default_nettype wire

// File: tb/tb_dec2onehot_led.sv
`default_nettype none
// ============================================================================
// Module      : tb_dec2onehot_led
// Description : Self-checking bench for dec2onehot_led. A schedule-based
//               reference model computes when each accepted digit starts
//               showing: start = max(accept_edge + 1, prev_start + HOLD + GAP).
//               LED, busy, ready and sticky-invalid are derived from that
//               schedule every cycle and compared against the design.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dec2onehot_led;

  localparam int DEPTH = 4;
  localparam int HOLD  = 4;
  localparam int GAP   = 2;

  logic       clk   = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear = 1'b0;
  logic [9:0] led;
  logic       busy;
  logic       inv_seen;

  dec2onehot_led_if u_if ();

  dec2onehot_led #(
    .DEPTH    (DEPTH),
    .HOLD_CYC (HOLD),
    .GAP_CYC  (GAP),
    .CNT_W    (3)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .s_digit        (u_if),
    .i_clear        (clear),
    .o_led          (led),
    .o_busy         (busy),
    .o_invalid_seen (inv_seen)
  );

  always #5 clk = ~clk;

  // --------------------------------------------------------------------------
  // Reference model: list of accepted digits with their display start edge.
  // --------------------------------------------------------------------------
  typedef struct {
    logic [3:0] d;
    longint     start;
  } ent_t;

  ent_t   q[$];
  longint last_start;
  longint t;
  logic   m_inv;
  logic   m_ready;
  int     n_vec;
  int     n_fail;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, obs, exp, t);
    end
  endtask

  function automatic logic [9:0] pattern(input logic [3:0] d);
    if (d < 4'd10) return 10'(1 << d);
    return 10'h3FF;
  endfunction

  task automatic model_flush();
    q.delete();
    last_start = -1000;
    m_inv      = 1'b0;
    m_ready    = 1'b1;
  endtask

  task automatic check_outputs();
    logic [9:0] e_led;
    int         pending;
    e_led   = '0;
    pending = 0;
    foreach (q[i]) begin
      if (q[i].start <= t && t < q[i].start + HOLD) e_led = pattern(q[i].d);
      if (q[i].start > t) pending++;
    end
    m_ready = (pending < DEPTH);
    chk("led",     {22'b0, led},               {22'b0, e_led});
    chk("busy",    {31'b0, busy},              {31'b0, (q.size() != 0)});
    chk("ready",   {31'b0, u_if.digit_ready},  {31'b0, m_ready});
    chk("invalid", {31'b0, inv_seen},          {31'b0, m_inv});
  endtask

  // One clock cycle: drive on the falling edge, update model at the rising
  // edge, compare 1 time unit later.
  task automatic cycle(input logic v, input logic [3:0] d, input logic clr, output logic acc);
    longint s;
    @(negedge clk);
    u_if.digit_valid = v;
    u_if.digit_in    = d;
    clear            = clr;
    acc              = v & m_ready & ~clr;
    @(posedge clk);
    t++;
    if (clr) begin
      model_flush();
    end else if (acc) begin
      s = (t + 1 > last_start + HOLD + GAP) ? t + 1 : last_start + HOLD + GAP;
      q.push_back('{d, s});
      last_start = s;
    end
    foreach (q[i]) begin
      if (q[i].start == t && q[i].d > 4'd9) m_inv = 1'b1;
    end
    while (q.size() > 0 && q[0].start + HOLD + GAP <= t) void'(q.pop_front());
    #1;
    check_outputs();
  endtask

  task automatic idle(input int n);
    logic acc;
    for (int i = 0; i < n; i++) cycle(1'b0, 4'h0, 1'b0, acc);
  endtask

  task automatic push_digit(input logic [3:0] d);
    logic acc;
    acc = 1'b0;
    for (int i = 0; i < 50 && !acc; i++) cycle(1'b1, d, 1'b0, acc);
    chk("push_accepted", {31'b0, acc}, 32'd1);
  endtask

  // Asynchronous reset pulse placed strictly between clock edges.
  task automatic async_reset_pulse();
    logic acc;
    cycle(1'b0, 4'h0, 1'b0, acc);
    #1 rst_n = 1'b0;
    #1;
    model_flush();
    check_outputs();
    #1 rst_n = 1'b1;
  endtask

  logic        acc_r;
  logic [3:0]  rd;

  initial begin
    n_vec = 0;
    n_fail = 0;
    t = 0;
    u_if.digit_valid = 1'b0;
    u_if.digit_in    = 4'h0;
    model_flush();

    // Reset state
    #2;
    check_outputs();
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;

    // Single valid digit, then full drain
    push_digit(4'h3);
    idle(10);

    // Invalid code lights all LEDs, sticky flag persists
    push_digit(4'hB);
    idle(10);
    push_digit(4'h6);
    idle(10);

    // Back-to-back burst overfills the FIFO briefly
    for (int i = 0; i < 6; i++) push_digit(4'(i));
    idle(45);

    // Clear during SHOW with digits queued; a digit offered with clear is lost
    for (int i = 5; i < 9; i++) push_digit(4'(i));
    idle(2);
    cycle(1'b1, 4'h9, 1'b1, acc_r);
    idle(12);

    // Asynchronous reset while showing a digit
    push_digit(4'h7);
    idle(2);
    async_reset_pulse();
    idle(4);

    // Randomised traffic with occasional clears and resets
    for (int blk = 0; blk < 6; blk++) begin
      int dens;
      dens = $urandom_range(1, 8);
      for (int i = 0; i < 400; i++) begin
        rd = ($urandom_range(0, 7) == 0) ? 4'($urandom_range(10, 15)) : 4'($urandom_range(0, 9));
        cycle(($urandom_range(0, 9) < dens), rd, ($urandom_range(0, 99) == 0), acc_r);
      end
      async_reset_pulse();
    end
    idle(30);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule : tb_dec2onehot_led
`default_nettype wire
